// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register: hold, shift right, shift left and
//               parallel load, with a saturating count of shifts performed
//               since the last load or reset.
//
// Parameters  : WIDTH      register width in bits (2..64)
//               RESET_VAL  value loaded into q on reset
//               CW         shift counter width, ceil(log2(WIDTH+1))
//
// Ports       : clk      in   clock, rising edge
//               rst      in   synchronous active-high reset
//               en       in   operation enable (0 = hold)
//               mode     in   00 hold, 01 shift right, 10 shift left, 11 load
//               rot      in   (USHIFT_ROTATE_EN only) rotate instead of shift
//               d        in   parallel load data
//               sin_r    in   serial input entering at MSB on shift right
//               sin_l    in   serial input entering at LSB on shift left
//               q        out  register contents
//               qbar     out  ~q
//               sout_r   out  q[0]
//               sout_l   out  q[WIDTH-1]
//               cnt      out  shifts since load/reset, saturating at WIDTH
//               drained  out  cnt == WIDTH
//
// Build macro : USHIFT_ROTATE_EN adds the rot input.
//
// Revision    : 1.0  initial release
// ============================================================================
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
`ifdef USHIFT_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             drained
);

  localparam logic [1:0]    C_MODE_HOLD  = 2'b00;
  localparam logic [1:0]    C_MODE_RIGHT = 2'b01;
  localparam logic [1:0]    C_MODE_LEFT  = 2'b10;
  localparam logic [1:0]    C_MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] C_CNT_FULL   = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_in_r;
  logic             w_in_l;

  // Bits entering on each shift. With rotation enabled the exiting bit
  // wraps to the opposite end and the serial inputs are not used.
`ifdef USHIFT_ROTATE_EN
  assign w_in_r = rot ? r_q[0]       : sin_r;
  assign w_in_l = rot ? r_q[WIDTH-1] : sin_l;
`else
  assign w_in_r = sin_r;
  assign w_in_l = sin_l;
`endif

  // Saturating increment: the count stops at WIDTH while shifting continues.
  assign w_cnt_inc = (r_cnt == C_CNT_FULL) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_q_nxt   = r_q;
    w_cnt_nxt = r_cnt;
    if (en) begin
      case (mode)
        C_MODE_RIGHT: begin
          w_q_nxt   = {w_in_r, r_q[WIDTH-1:1]};
          w_cnt_nxt = w_cnt_inc;
        end
        C_MODE_LEFT: begin
          w_q_nxt   = {r_q[WIDTH-2:0], w_in_l};
          w_cnt_nxt = w_cnt_inc;
        end
        C_MODE_LOAD: begin
          w_q_nxt   = d;
          w_cnt_nxt = '0;
        end
        C_MODE_HOLD: begin
          w_q_nxt   = r_q;
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_q_nxt   = r_q;
          w_cnt_nxt = r_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RESET_VAL;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign sout_r  = r_q[0];
  assign sout_l  = r_q[WIDTH-1];
  assign cnt     = r_cnt;
  assign drained = (r_cnt == C_CNT_FULL);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg (WIDTH=8,
//               RESET_VAL=0). An arithmetic reference model tracks the
//               register value and shift count; outputs are compared with it
//               every falling edge, and directed sequences pin known values.
//               Rotation sequences run when USHIFT_ROTATE_EN is defined.
//
// Revision    : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             rot;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             drained;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
`ifdef USHIFT_ROTATE_EN
    .rot     (rot),
`endif
    .d       (d),
    .sin_r   (sin_r),
    .sin_l   (sin_l),
    .q       (q),
    .qbar    (qbar),
    .sout_r  (sout_r),
    .sout_l  (sout_l),
    .cnt     (cnt),
    .drained (drained)
  );

  always #5 clk = ~clk;

  // Reference model: value as an integer 0..255, shifts as divide/multiply.
  int m_q     = 0;
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int ent;
    if (rst) begin
      m_q     = 0;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else if (en && mode != 2'b00) begin
      if (mode == 2'b11) begin
        m_q   = int'(d);
        m_cnt = 0;
      end else begin
        if (mode == 2'b01) begin
          ent = int'(sin_r);
`ifdef USHIFT_ROTATE_EN
          if (rot) ent = m_q % 2;
`endif
          m_q = m_q / 2 + ent * 128;
        end else begin
          ent = int'(sin_l);
`ifdef USHIFT_ROTATE_EN
          if (rot) ent = m_q / 128;
`endif
          m_q = (m_q * 2) % 256 + ent;
        end
        if (m_cnt < WIDTH) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q",       64'(q),       64'(m_q));
      check("model_qbar",    64'(qbar),    64'(255 - m_q));
      check("model_sout_r",  64'(sout_r),  64'(m_q % 2));
      check("model_sout_l",  64'(sout_l),  64'(m_q / 128));
      check("model_cnt",     64'(cnt),     64'(m_cnt));
      check("model_drained", 64'(drained), 64'(m_cnt == WIDTH));
    end
  end

  // Apply one set of inputs for one rising edge; returns #1 after that edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] dd, input logic sr, input logic sl,
                      input logic rt);
    rst   = r;
    en    = e;
    mode  = m;
    d     = dd;
    sin_r = sr;
    sin_l = sl;
    rot   = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; d = '0;
    sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;

    // Reset
    step(1, 0, 2'b00, 8'h00, 0, 0, 0);
    check("rst_q",       64'(q),       64'h00);
    check("rst_qbar",    64'(qbar),    64'hFF);
    check("rst_cnt",     64'(cnt),     64'd0);
    check("rst_drained", 64'(drained), 64'd0);

    // Load A5, shift right three with sin_r=0
    step(0, 1, 2'b11, 8'hA5, 0, 0, 0);
    check("load_a5", 64'(q), 64'hA5);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 8'h00, 0, 1, 0);
    check("sr3_q",      64'(q),      64'h14);
    check("sr3_cnt",    64'(cnt),    64'd3);
    check("sr3_sout_r", 64'(sout_r), 64'd0);

    // Load 81, eight left shifts with sin_l=1, then saturation
    step(0, 1, 2'b11, 8'h81, 0, 0, 0);
    check("load_81_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b10, 8'h00, 0, 1, 0);
    check("sl8_q",       64'(q),       64'hFF);
    check("sl8_cnt",     64'(cnt),     64'd8);
    check("sl8_drained", 64'(drained), 64'd1);
    for (int i = 0; i < 2; i++) step(0, 1, 2'b10, 8'h00, 0, 0, 0);
    check("sl10_cnt",    64'(cnt),     64'd8);
    check("sl10_q",      64'(q),       64'hFC);

    // Disabled: nothing changes
    step(0, 1, 2'b11, 8'h3C, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 2'b01, 8'hFF, 1, 1, 0);
      check("en0_q",   64'(q),   64'h3C);
      check("en0_cnt", 64'(cnt), 64'd0);
    end
    // mode 00 with en=1 also holds
    step(0, 1, 2'b00, 8'hFF, 1, 1, 0);
    check("hold_q", 64'(q), 64'h3C);

    // Mixed directions; opposite-direction serial input ignored
    step(0, 1, 2'b01, 8'h00, 1, 0, 0);   // 3C -> 9E
    step(0, 1, 2'b10, 8'h00, 1, 0, 0);   // 9E -> 3C
    step(0, 1, 2'b10, 8'h00, 0, 1, 0);   // 3C -> 79
    check("mix_q",   64'(q),   64'h79);
    check("mix_cnt", 64'(cnt), 64'd3);
    check("mix_sout_l", 64'(sout_l), 64'd0);

    // Reset mid-sequence overrides a load
    step(0, 1, 2'b11, 8'hF0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h00, 0, 0, 0);
    step(0, 1, 2'b01, 8'h00, 0, 0, 0);
    check("pre_rst_q", 64'(q), 64'h3C);
    step(1, 1, 2'b11, 8'h55, 0, 0, 0);
    check("midrst_q",   64'(q),   64'h00);
    check("midrst_cnt", 64'(cnt), 64'd0);

`ifdef USHIFT_ROTATE_EN
    step(0, 1, 2'b11, 8'h81, 0, 0, 0);
    step(0, 1, 2'b01, 8'h00, 0, 0, 1);
    check("rotr1_q", 64'(q), 64'hC0);
    step(0, 1, 2'b11, 8'h81, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b01, 8'h00, 0, 0, 1);
    check("rotr8_q",       64'(q),       64'h81);
    check("rotr8_drained", 64'(drained), 64'd1);
    step(0, 1, 2'b11, 8'h81, 0, 0, 0);
    step(0, 1, 2'b10, 8'h00, 0, 0, 1);
    check("rotl1_q", 64'(q), 64'h03);
`endif

    step(0, 0, 2'b00, 8'h00, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL define CW = ceil(log2(WIDTH+1)), the width of the shift counter.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port en  input  1  operation enable; 0 forces hold regardless of mode.
REQ-007 The block SHALL have port mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-009 The block SHALL have port sin_r  input  1  serial input entering at the MSB during shift right.
REQ-010 The block SHALL have port sin_l  input  1  serial input entering at the LSB during shift left.
REQ-011 The block SHALL have port q  output  WIDTH  registered contents.
REQ-012 The block SHALL have port qbar  output  WIDTH  bitwise complement of q, always.
REQ-013 The block SHALL have port sout_r  output  1  bit leaving on shift right, equal to q[0].
REQ-014 The block SHALL have port sout_l  output  1  bit leaving on shift left, equal to q[WIDTH-1].
REQ-015 The block SHALL have port cnt  output  CW  shifts performed since last load or reset, saturating at WIDTH.
REQ-016 The block SHALL have port drained  output  1  high when cnt equals WIDTH.

Function
REQ-017 Hold (en=0 or mode=00) SHALL leave q and cnt unchanged.
REQ-018 Shift right SHALL give next q = {sin_r, q[WIDTH-1:1]}, one bit per enabled cycle.
REQ-019 Shift left SHALL give next q = {q[WIDTH-2:0], sin_l}, one bit per enabled cycle.
REQ-020 Parallel load SHALL give next q = d and next cnt = 0, with one-cycle latency (visible the cycle after the edge).
REQ-021 Each enabled shift (either direction) SHALL increment cnt by 1 until WIDTH, then hold it at WIDTH while shifting continues.
REQ-022 qbar, sout_r, sout_l and drained SHALL be combinational from registered state, with no extra latency.
REQ-023 Direction changes between consecutive cycles SHALL be legal; cnt counts total shifts, not net displacement.
REQ-024 Serial inputs SHALL be sampled only in their own shift direction and ignored otherwise.

Reset
REQ-025 rst=1 at a rising edge SHALL set q=RESET_VAL and cnt=0, overriding en and mode.
REQ-026 After reset: qbar=~RESET_VAL, sout_r=RESET_VAL[0], sout_l=RESET_VAL[WIDTH-1], drained=0.
REQ-027 Reset asserted mid-shift sequence SHALL discard the sequence with no partial update.

Configuration
REQ-028 Macro USHIFT_ROTATE_EN defined SHALL add input port rot (1 bit): when rot=1 in a shift mode, the exiting bit re-enters at the opposite end (shift right q <= {q[0], q[WIDTH-1:1]}; shift left q <= {q[WIDTH-2:0], q[WIDTH-1]}), sin_r/sin_l ignored, cnt counts as for a shift.
REQ-029 Macro USHIFT_ROTATE_EN undefined SHALL omit port rot; shifts always use sin_r/sin_l.

Verification (WIDTH=8, RESET_VAL=0)
REQ-030 rst=1 one edge -> q=8'h00, qbar=8'hFF, cnt=0, drained=0.
REQ-031 en=1, mode=11, d=8'hA5, then mode=01, sin_r=0 for 3 cycles -> q=8'h14, cnt=3, sout_r=0.
REQ-032 Load 8'h81, mode=10, sin_l=1 for 8 cycles -> q=8'hFF, cnt=8, drained=1; 2 more shifts -> cnt stays 8.
REQ-033 Load 8'h3C, then en=0 with mode=01 for 5 cycles -> q=8'h3C, cnt=0 throughout.
REQ-034 Load 8'hF0, shift right 2 cycles, rst=1 on the third edge with mode=11, d=8'h55 -> q=8'h00, cnt=0.
REQ-035 With USHIFT_ROTATE_EN: load 8'h81, rot=1, mode=01 for 1 cycle -> q=8'hC0; 8 rotations from 8'h81 -> q=8'h81, drained=1.
